// File: rtl/commit_recovery_sequencer.sv
// Recovery sequencer: latches the refetch target, pulses fetch/CSR redirect,
// then walks squashed active-list entries back before returning to COMMIT.
module commit_recovery_sequencer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int AL_ENTRY_NUM = 64,
  parameter int PC_WIDTH = 32,
  localparam int CW = $clog2(AL_ENTRY_NUM + 1),
  localparam int NW = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exceptionReq,
  input  logic [2:0]          refetchType,
  input  logic [4:0]          recoveryCause,
  input  logic [PC_WIDTH-1:0] recoveryOpPC,
  input  logic [PC_WIDTH-1:0] branchTarget,
  input  logic [PC_WIDTH-1:0] csrTrapVector,
  input  logic [CW-1:0]       alValidNum,
  input  logic [NW-1:0]       commitNum,
  input  logic                csrBusy,
  output logic [1:0]          phase,
  output logic                unableToStartRecovery,
  output logic                walkValid,
  output logic [NW-1:0]       walkNum,
  output logic                refetchValid,
  output logic [PC_WIDTH-1:0] refetchPC,
  output logic                trapValid,
  output logic [4:0]          trapCause,
  output logic                recoveryDone
);

  typedef enum logic [1:0] {
    COMMIT    = 2'd0,
    RECOVER_0 = 2'd1,
    RECOVER_1 = 2'd2
  } phase_e;

  phase_e phaseQ, phaseD;
  logic [CW-1:0] remQ, remD;
  logic [CW-1:0] walkAmt;
  logic [CW-1:0] remAfterWalk;
  logic [PC_WIDTH-1:0] pcQ, pcD;
  logic [4:0] causeQ, causeD;
  logic trapQ, trapD;
  logic doneQ, doneD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phaseQ <= COMMIT;
      remQ   <= '0;
      pcQ    <= '0;
      causeQ <= '0;
      trapQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      phaseQ <= phaseD;
      remQ   <= remD;
      pcQ    <= pcD;
      causeQ <= causeD;
      trapQ  <= trapD;
      doneQ  <= doneD;
    end
  end

  always_comb begin
    if (remQ > CW'(COMMIT_WIDTH)) walkAmt = CW'(COMMIT_WIDTH);
    else walkAmt = remQ;
    remAfterWalk = remQ - walkAmt;
  end

  always_comb begin
    phaseD       = phaseQ;
    remD         = remQ;
    pcD          = pcQ;
    causeD       = causeQ;
    trapD        = trapQ;
    doneD        = 1'b0;
    refetchValid = 1'b0;
    trapValid    = 1'b0;
    walkValid    = 1'b0;
    walkNum      = '0;
    unique case (phaseQ)
      COMMIT: begin
        if (exceptionReq) begin
          phaseD = RECOVER_0;
          remD   = alValidNum - CW'(commitNum);
          causeD = recoveryCause;
          trapD  = (refetchType == 3'd4) || (refetchType == 3'd5);
          // 6/7 are unused encodings and fall back to THIS_PC
          case (refetchType)
            3'd1, 3'd3: pcD = recoveryOpPC + PC_WIDTH'(4);
            3'd2:       pcD = branchTarget;
            3'd4, 3'd5: pcD = csrTrapVector;
            default:    pcD = recoveryOpPC;
          endcase
        end
      end
      RECOVER_0: begin
        refetchValid = 1'b1;
        trapValid    = trapQ;
        if (remQ == '0) begin
          phaseD = COMMIT;
          doneD  = 1'b1;
        end else begin
          phaseD = RECOVER_1;
        end
      end
      RECOVER_1: begin
        walkValid = 1'b1;
        walkNum   = NW'(walkAmt);
        remD      = remAfterWalk;
        if (remAfterWalk == '0) begin
          phaseD = COMMIT;
          doneD  = 1'b1;
        end
      end
      default: phaseD = COMMIT;
    endcase
  end

  assign phase = phaseQ;
  assign unableToStartRecovery = (phaseQ != COMMIT) | csrBusy;
  assign refetchPC = pcQ;
  assign trapCause = causeQ;
  assign recoveryDone = doneQ;

endmodule

// File: tb/tb_commit_recovery_sequencer.sv
// Randomized scoreboard bench for commit_recovery_sequencer: a queue-based
// reference model predicts phases and the ordered refetch/walk/done events.
module tb_commit_recovery_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, exceptionReq, csrBusy;
  logic [2:0] refetchType;
  logic [4:0] recoveryCause;
  logic [31:0] recoveryOpPC, branchTarget, csrTrapVector;
  logic [6:0] alValidNum;
  logic [1:0] commitNum;
  logic [1:0] phase;
  logic unableToStartRecovery, walkValid, refetchValid, trapValid, recoveryDone;
  logic [1:0] walkNum;
  logic [31:0] refetchPC;
  logic [4:0] trapCause;

  commit_recovery_sequencer dut (
    .clk(clk), .rst(rst), .exceptionReq(exceptionReq),
    .refetchType(refetchType), .recoveryCause(recoveryCause),
    .recoveryOpPC(recoveryOpPC), .branchTarget(branchTarget),
    .csrTrapVector(csrTrapVector), .alValidNum(alValidNum),
    .commitNum(commitNum), .csrBusy(csrBusy), .phase(phase),
    .unableToStartRecovery(unableToStartRecovery),
    .walkValid(walkValid), .walkNum(walkNum),
    .refetchValid(refetchValid), .refetchPC(refetchPC),
    .trapValid(trapValid), .trapCause(trapCause),
    .recoveryDone(recoveryDone)
  );

  typedef struct {
    int kind;
    logic [31:0] pc;
    logic trap;
    logic [4:0] cause;
    int num;
  } ev_t;

  ev_t evq[$];
  int phq[$];
  int checks = 0;
  int failures = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic popEv(input int kind, output ev_t e, output bit ok);
    ok = 0;
    if (evq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=kind%0d expected=none", kind);
    end else begin
      e = evq.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  function automatic logic [31:0] modelPC(input logic [2:0] ty,
      input logic [31:0] pc, input logic [31:0] bt, input logic [31:0] vec);
    if (ty == 1 || ty == 3) return pc + 32'd4;
    if (ty == 2) return bt;
    if (ty == 4 || ty == 5) return vec;
    return pc;
  endfunction

  task automatic accept();
    int rem;
    int w;
    ev_t e;
    rem = int'(alValidNum) - int'(commitNum);
    e.kind = 0;
    e.pc = modelPC(refetchType, recoveryOpPC, branchTarget, csrTrapVector);
    e.trap = (refetchType == 4) || (refetchType == 5);
    e.cause = recoveryCause;
    e.num = 0;
    evq.push_back(e);
    phq.push_back(1);
    while (rem > 0) begin
      w = (rem > 2) ? 2 : rem;
      e.kind = 1;
      e.num = w;
      evq.push_back(e);
      phq.push_back(2);
      rem -= w;
    end
    e.kind = 2;
    e.num = 0;
    evq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic req, input logic [2:0] ty,
      input logic [4:0] cause, input logic [31:0] pc, input logic [31:0] bt,
      input logic [31:0] vec, input logic [6:0] al, input logic [1:0] cn,
      input logic busy);
    int expPh;
    @(negedge clk);
    rst = r; exceptionReq = req; refetchType = ty; recoveryCause = cause;
    recoveryOpPC = pc; branchTarget = bt; csrTrapVector = vec;
    alValidNum = al; commitNum = cn; csrBusy = busy;
    #1;
    if (started) begin
      expPh = (phq.size() > 0) ? phq[0] : 0;
      chk("phase", 64'(phase), 64'(expPh));
      chk("unableToStartRecovery", 64'(unableToStartRecovery),
          64'((expPh != 0) || busy));
    end
    @(posedge clk);
    if (!r) begin
      evq.delete();
      phq.delete();
      started = 1;
    end else if (phq.size() == 0) begin
      if (req) accept();
    end else begin
      void'(phq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 7'd0, 2'd0, 0);
  endtask

  always @(posedge clk) begin
    ev_t e;
    bit ok;
    #1;
    if (started) begin
      if (refetchValid) begin
        popEv(0, e, ok);
        if (ok) begin
          chk("refetchPC", 64'(refetchPC), 64'(e.pc));
          chk("trapValid", 64'(trapValid), 64'(e.trap));
          chk("trapCause", 64'(trapCause), 64'(e.cause));
        end
      end else begin
        chk("trapValid_idle", 64'(trapValid), 64'd0);
      end
      if (walkValid) begin
        popEv(1, e, ok);
        if (ok) chk("walkNum", 64'(walkNum), 64'(e.num));
      end
      if (recoveryDone) popEv(2, e, ok);
    end
  end

  initial begin
    int al;
    int cn;
    rst = 0; exceptionReq = 0; refetchType = 0; recoveryCause = 0;
    recoveryOpPC = 0; branchTarget = 0; csrTrapVector = 0;
    alValidNum = 0; commitNum = 0; csrBusy = 0;
    drive(0, 1, 1, 3, 32'h1000, 32'h0, 32'h0, 7'd5, 2'd1, 0);
    drive(0, 1, 1, 3, 32'h1000, 32'h0, 32'h0, 7'd5, 2'd1, 1);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 7'd0, 2'd0, 1);
    drive(1, 1, 1, 0, 32'h1000, 32'h0, 32'h0, 7'd5, 2'd1, 0);
    idle(5);
    drive(1, 1, 2, 1, 32'h1100, 32'h2000, 32'h0, 7'd1, 2'd1, 0);
    idle(3);
    drive(1, 1, 5, 5, 32'h1200, 32'h0, 32'h80, 7'd3, 2'd1, 0);
    idle(4);
    for (int i = 0; i < 6; i++)
      drive(1, 1, 0, 2, 32'h3000, 32'h0, 32'h0, 7'd6, 2'd0, 0);
    idle(6);
    drive(1, 1, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 7'd2, 2'd2, 0);
    idle(3);
    drive(1, 1, 0, 7, 32'h4000, 32'h0, 32'h0, 7'd20, 2'd0, 0);
    idle(3);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 7'd0, 2'd0, 0);
    idle(2);
    for (int i = 0; i < 800; i++) begin
      al = $urandom_range(0, 64);
      cn = $urandom_range(0, (al < 2) ? al : 2);
      drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)), 5'($urandom),
            32'($urandom), 32'($urandom), 32'($urandom),
            7'(al), 2'(cn), 1'($urandom_range(0, 1)));
    end
    idle(40);
    chk("queue_drained", 64'(evq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
